// File: rtl/rv_imm_pkg.sv
// Shared format codes, RV opcodes and skid-buffer state encoding for the
// immediate-generation stage.
package rv_imm_pkg;

  typedef logic [2:0] fmt_t;

  localparam fmt_t FMT_NONE  = 3'd0;
  localparam fmt_t FMT_I     = 3'd1;
  localparam fmt_t FMT_S     = 3'd2;
  localparam fmt_t FMT_B     = 3'd3;
  localparam fmt_t FMT_U     = 3'd4;
  localparam fmt_t FMT_J     = 3'd5;
  localparam fmt_t FMT_SHAMT = 3'd6;

  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_FENCE     = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_JAL       = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM    = 7'h73;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_t;

  // SLLI/SRLI/SRAI share funct3 x01; everything else in OP-IMM is a plain I-type.
  function automatic logic is_shift(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word to sign-extended immediate,
// format code and illegal-encoding flag.
module imm_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64) && (RV64_OPS != 0);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] shamt5;
  logic [XLEN-1:0] shamt6;

  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign shamt5 = XLEN'(instr[24:20]);
  assign shamt6 = XLEN'(instr[25:20]);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
          fmt = FMT_I;
          imm = imm_i;
        end
        OPC_OP_IMM: begin
          if (is_shift(instr[14:12])) begin
            fmt = FMT_SHAMT;
            if (RV64) begin
              imm = shamt6;
            end else begin
              imm     = shamt5;
              illegal = instr[25];
            end
          end else begin
            fmt = FMT_I;
            imm = imm_i;
          end
        end
        OPC_OP_IMM_32: begin
          if (!RV64) begin
            illegal = 1'b1;
          end else if (is_shift(instr[14:12])) begin
            fmt     = FMT_SHAMT;
            imm     = shamt5;
            illegal = instr[25];
          end else begin
            fmt = FMT_I;
            imm = imm_i;
          end
        end
        OPC_STORE: begin
          fmt = FMT_S;
          imm = imm_s;
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          imm = imm_b;
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          imm = imm_u;
        end
        OPC_JAL: begin
          fmt = FMT_J;
          imm = imm_j;
        end
        OPC_OP, OPC_FENCE: ;
        OPC_OP_32: illegal = !RV64;
        default:   illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode plus PC-relative target ahead of
// a two-entry skid buffer with valid/ready on both sides.
module imm_gen_stage
  import rv_imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output fmt_t            out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            dec_illegal;
  logic            has_target;
  entry_t          new_entry;

  imm_decode #(
    .XLEN     (XLEN),
    .RV64_OPS (RV64_OPS)
  ) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // JALR is excluded on purpose: its target depends on rs1.
  assign has_target = (dec_fmt == FMT_B) || (dec_fmt == FMT_J) ||
                      (in_instr[6:0] == OPC_AUIPC);

  always_comb begin
    new_entry.imm     = dec_imm;
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
    new_entry.pc      = in_pc;
    new_entry.target  = has_target ? in_pc + dec_imm : '0;
  end

  buf_state_t state_q;
  buf_state_t state_d;
  entry_t     m_q;
  entry_t     k_q;
  logic       in_ready_q;
  logic       load_m;
  logic       load_k;
  logic       m_from_k;

  // In EMPTY and ONE the stage is always ready, so in_valid alone means a push.
  always_comb begin
    state_d  = state_q;
    load_m   = 1'b0;
    load_k   = 1'b0;
    m_from_k = 1'b0;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_valid) begin
            load_m  = 1'b1;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (out_ready) begin
            if (in_valid) load_m = 1'b1;
            else          state_d = BUF_EMPTY;
          end else if (in_valid) begin
            load_k  = 1'b1;
            state_d = BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (out_ready) begin
            m_from_k = 1'b1;
            state_d  = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_FULL);
      if (load_m)        m_q <= new_entry;
      else if (m_from_k) m_q <= k_q;
    end
  end

  // NOTE: skid data has no reset; it is only ever read while the FULL state marks it valid.
  always_ff @(posedge clk) begin
    if (load_k) k_q <= new_entry;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != BUF_EMPTY);
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;
  assign out_pc      = m_q.pc;
  assign out_target  = m_q.target;

endmodule
